mole_scheduler: RTL and testbench

MOLE_SCHEDULER -- requirements
Module: mole_scheduler

---
 rtl/mole_scheduler.sv | 175 +++++++++++++++++
 tb/tb_mole_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_scheduler.sv
// Whack-a-mole game sequencer: spawns pseudo-random moles, scores hits and counts down the game clock.
// Every output is a registered decode of the next state or of next-cycle event flags.
module mole_scheduler #(
    parameter int unsigned GAME_SECONDS = 30,
    parameter int unsigned MOLE_TICKS   = 3,
    parameter int unsigned GAP_TICKS    = 1,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       hit_valid,
    input  logic [3:0] hit_idx,
    output logic       mole_en,
    output logic [3:0] mole_idx,
    output logic [7:0] score,
    output logic [6:0] time_left,
    output logic       busy,
    output logic       game_over,
    output logic       hit_ok,
    output logic       miss
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_UP,
        S_GAP,
        S_DONE
    } state_t;

    state_t     r_state;
    logic [7:0] r_lfsr;
    logic [3:0] r_mole_idx;
    logic [7:0] r_score;
    logic [6:0] r_time_left;
    logic [3:0] r_up_cnt;
    logic [3:0] r_gap_cnt;
    logic       r_mole_en;
    logic       r_busy;
    logic       r_game_over;
    logic       r_hit_ok;
    logic       r_miss;

    state_t     w_state;
    logic [7:0] w_lfsr;
    logic [3:0] w_mole_idx;
    logic [7:0] w_score;
    logic [6:0] w_time_left;
    logic [3:0] w_up_cnt;
    logic [3:0] w_gap_cnt;
    logic       w_hit_ok;
    logic       w_miss;
    logic       w_hit_match;
    logic       w_in_game;
    logic       w_next_busy;
    logic [3:0] w_spawn_idx;

    // Feedback from bits 8,6,5,4 of x^8+x^6+x^5+x^4+1; the map is invertible so a nonzero seed never reaches zero.
    assign w_lfsr      = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_hit_match = hit_valid && (hit_idx == r_mole_idx);
    assign w_in_game   = (r_state == S_SPAWN) || (r_state == S_UP) || (r_state == S_GAP);
    assign w_spawn_idx = (r_lfsr[3:0] == r_mole_idx) ? (r_lfsr[3:0] + 4'd1) : r_lfsr[3:0];
    assign w_next_busy = (w_state == S_SPAWN) || (w_state == S_UP) || (w_state == S_GAP);

    always_comb begin
        w_state     = r_state;
        w_mole_idx  = r_mole_idx;
        w_score     = r_score;
        w_time_left = r_time_left;
        w_up_cnt    = r_up_cnt;
        w_gap_cnt   = r_gap_cnt;
        w_hit_ok    = 1'b0;
        w_miss      = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_score     = 8'd0;
                    w_time_left = 7'(GAME_SECONDS);
                    w_state     = S_SPAWN;
                end
            end
            S_SPAWN: begin
                w_mole_idx = w_spawn_idx;
                w_up_cnt   = 4'(MOLE_TICKS);
                w_state    = S_UP;
            end
            S_UP: begin
                if (w_hit_match) begin
                    w_score   = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
                    w_hit_ok  = 1'b1;
                    w_gap_cnt = 4'(GAP_TICKS);
                    w_state   = S_GAP;
                end else begin
                    if (hit_valid) begin
                        w_miss = 1'b1;
                    end
                    if (tick) begin
                        if (r_up_cnt == 4'd1) begin
                            w_miss    = 1'b1;
                            w_up_cnt  = 4'd0;
                            w_gap_cnt = 4'(GAP_TICKS);
                            w_state   = S_GAP;
                        end else begin
                            w_up_cnt = r_up_cnt - 4'd1;
                        end
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (r_gap_cnt == 4'd1) begin
                        w_gap_cnt = 4'd0;
                        w_state   = S_SPAWN;
                    end else begin
                        w_gap_cnt = r_gap_cnt - 4'd1;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase

        // The game clock runs in every in-game state and its expiry overrides any transition chosen above.
        if (w_in_game && tick) begin
            if (r_time_left == 7'd1) begin
                w_time_left = 7'd0;
                w_state     = S_DONE;
            end else begin
                w_time_left = r_time_left - 7'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_lfsr      <= LFSR_SEED;
            r_mole_idx  <= 4'd0;
            r_score     <= 8'd0;
            r_time_left <= 7'd0;
            r_up_cnt    <= 4'd0;
            r_gap_cnt   <= 4'd0;
            r_mole_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_game_over <= 1'b0;
            r_hit_ok    <= 1'b0;
            r_miss      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_lfsr      <= w_lfsr;
            r_mole_idx  <= w_mole_idx;
            r_score     <= w_score;
            r_time_left <= w_time_left;
            r_up_cnt    <= w_up_cnt;
            r_gap_cnt   <= w_gap_cnt;
            r_mole_en   <= (w_state == S_UP);
            r_busy      <= w_next_busy;
            r_game_over <= (w_state == S_DONE);
            r_hit_ok    <= w_hit_ok;
            r_miss      <= w_miss;
        end
    end

    assign mole_en   = r_mole_en;
    assign mole_idx  = r_mole_idx;
    assign score     = r_score;
    assign time_left = r_time_left;
    assign busy      = r_busy;
    assign game_over = r_game_over;
    assign hit_ok    = r_hit_ok;
    assign miss      = r_miss;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler with a short game (5 ticks, moles up 2 ticks, 1-tick gap).
// The expected mole hole comes from an independent software model of the 8-bit LFSR.
module tb_mole_scheduler;

    localparam int unsigned GAME = 5;
    localparam int unsigned MOLE = 2;
    localparam int unsigned GAP  = 1;
    localparam logic [7:0]  SEED = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       hit_valid = 1'b0;
    logic [3:0] hit_idx = 4'd0;
    logic       mole_en;
    logic [3:0] mole_idx;
    logic [7:0] score;
    logic [6:0] time_left;
    logic       busy;
    logic       game_over;
    logic       hit_ok;
    logic       miss;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] m_lfsr = SEED;
    logic [7:0] m_prev = SEED;
    logic [3:0] m_mole = 4'd0;
    logic [3:0] old_mole;

    mole_scheduler #(
        .GAME_SECONDS(GAME),
        .MOLE_TICKS  (MOLE),
        .GAP_TICKS   (GAP),
        .LFSR_SEED   (SEED)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .start    (start),
        .hit_valid(hit_valid),
        .hit_idx  (hit_idx),
        .mole_en  (mole_en),
        .mole_idx (mole_idx),
        .score    (score),
        .time_left(time_left),
        .busy     (busy),
        .game_over(game_over),
        .hit_ok   (hit_ok),
        .miss     (miss)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_mole(input logic [3:0] nib, input logic [3:0] prev);
        return (nib == prev) ? nib + 4'd1 : nib;
    endfunction

    // One clock: track the LFSR model, sample 1 time unit after the edge, then drop the one-cycle pulses.
    task automatic step();
        @(posedge clk);
        m_prev = m_lfsr;
        if (rst) m_lfsr = SEED;
        else     m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        #1;
        tick = 1'b0;
        start = 1'b0;
        hit_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_mole = 4'd0;
        n_checks++;
        if ({mole_en, busy, game_over, hit_ok, miss} !== 5'b0) begin
            n_errors++;
            $display("[TB] FAIL reset_flags: got %b expected 00000", {mole_en, busy, game_over, hit_ok, miss});
        end
        n_checks++;
        if ({score, time_left, mole_idx} !== 19'd0) begin
            n_errors++;
            $display("[TB] FAIL reset_values: score=%0d time=%0d idx=%0d expected all 0", score, time_left, mole_idx);
        end
    endtask

    task automatic test_start();
        start = 1'b1;
        step();
        n_checks++;
        if (busy !== 1'b1 || time_left !== 7'd5 || score !== 8'd0 || mole_en !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL start: busy=%b time=%0d score=%0d mole_en=%b expected 1 5 0 0", busy, time_left, score, mole_en);
        end
        step();
        m_mole = exp_mole(m_prev[3:0], m_mole);
        n_checks++;
        if (mole_en !== 1'b1 || mole_idx !== m_mole) begin
            n_errors++;
            $display("[TB] FAIL first_mole: mole_en=%b idx=%0d expected 1 %0d", mole_en, mole_idx, m_mole);
        end
    endtask

    task automatic test_hit();
        hit_valid = 1'b1;
        hit_idx = m_mole;
        step();
        n_checks++;
        if (hit_ok !== 1'b1 || miss !== 1'b0 || score !== 8'd1 || mole_en !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL hit: hit_ok=%b miss=%b score=%0d mole_en=%b expected 1 0 1 0", hit_ok, miss, score, mole_en);
        end
        step();
        n_checks++;
        if (hit_ok !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL hit_pulse_width: hit_ok=%b expected 0", hit_ok);
        end
        tick = 1'b1;
        step();
        n_checks++;
        if (time_left !== 7'd4 || mole_en !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL gap_tick: time=%0d mole_en=%b expected 4 0", time_left, mole_en);
        end
        step();
        old_mole = m_mole;
        m_mole = exp_mole(m_prev[3:0], m_mole);
        n_checks++;
        if (mole_en !== 1'b1 || mole_idx !== m_mole || mole_idx === old_mole) begin
            n_errors++;
            $display("[TB] FAIL respawn: mole_en=%b idx=%0d expected 1 %0d (prev %0d)", mole_en, mole_idx, m_mole, old_mole);
        end
    endtask

    task automatic test_miss();
        hit_valid = 1'b1;
        hit_idx = m_mole ^ 4'd1;
        step();
        n_checks++;
        if (miss !== 1'b1 || hit_ok !== 1'b0 || score !== 8'd1 || mole_en !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL wrong_hole: miss=%b hit_ok=%b score=%0d mole_en=%b expected 1 0 1 1", miss, hit_ok, score, mole_en);
        end
        step();
        n_checks++;
        if (miss !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL miss_pulse_width: miss=%b expected 0", miss);
        end
        tick = 1'b1;
        step();
        n_checks++;
        if (mole_en !== 1'b1 || miss !== 1'b0 || time_left !== 7'd3) begin
            n_errors++;
            $display("[TB] FAIL first_up_tick: mole_en=%b miss=%b time=%0d expected 1 0 3", mole_en, miss, time_left);
        end
        tick = 1'b1;
        step();
        n_checks++;
        if (mole_en !== 1'b0 || miss !== 1'b1 || time_left !== 7'd2 || score !== 8'd1) begin
            n_errors++;
            $display("[TB] FAIL timeout: mole_en=%b miss=%b time=%0d score=%0d expected 0 1 2 1", mole_en, miss, time_left, score);
        end
    endtask

    task automatic test_final_tick();
        start = 1'b1;
        step();
        n_checks++;
        if (busy !== 1'b1 || time_left !== 7'd2 || score !== 8'd1 || mole_en !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL start_ignored: busy=%b time=%0d score=%0d mole_en=%b expected 1 2 1 0", busy, time_left, score, mole_en);
        end
        tick = 1'b1;
        step();
        step();
        m_mole = exp_mole(m_prev[3:0], m_mole);
        n_checks++;
        if (mole_en !== 1'b1 || mole_idx !== m_mole || time_left !== 7'd1) begin
            n_errors++;
            $display("[TB] FAIL last_mole: mole_en=%b idx=%0d time=%0d expected 1 %0d 1", mole_en, mole_idx, time_left, m_mole);
        end
        tick = 1'b1;
        hit_valid = 1'b1;
        hit_idx = m_mole;
        step();
        n_checks++;
        if (score !== 8'd2 || hit_ok !== 1'b1 || miss !== 1'b0 || game_over !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL final_hit: score=%0d hit_ok=%b miss=%b over=%b expected 2 1 0 1", score, hit_ok, miss, game_over);
        end
        n_checks++;
        if (time_left !== 7'd0 || busy !== 1'b0 || mole_en !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL done_state: time=%0d busy=%b mole_en=%b expected 0 0 0", time_left, busy, mole_en);
        end
        tick = 1'b1;
        step();
        n_checks++;
        if (game_over !== 1'b1 || score !== 8'd2 || hit_ok !== 1'b0 || time_left !== 7'd0) begin
            n_errors++;
            $display("[TB] FAIL done_hold: over=%b score=%0d hit_ok=%b time=%0d expected 1 2 0 0", game_over, score, hit_ok, time_left);
        end
        start = 1'b1;
        step();
        n_checks++;
        if (score !== 8'd0 || time_left !== 7'd5 || busy !== 1'b1 || game_over !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL restart: score=%0d time=%0d busy=%b over=%b expected 0 5 1 0", score, time_left, busy, game_over);
        end
        step();
        m_mole = exp_mole(m_prev[3:0], m_mole);
    endtask

    task automatic test_reset_midgame();
        for (int k = 0; k < 3; k++) begin
            hit_valid = 1'b1;
            hit_idx = m_mole;
            step();
            tick = 1'b1;
            step();
            step();
            m_mole = exp_mole(m_prev[3:0], m_mole);
        end
        n_checks++;
        if (score !== 8'd3 || mole_en !== 1'b1 || mole_idx !== m_mole || time_left !== 7'd2) begin
            n_errors++;
            $display("[TB] FAIL third_score: score=%0d mole_en=%b idx=%0d time=%0d expected 3 1 %0d 2", score, mole_en, mole_idx, time_left, m_mole);
        end
        rst = 1'b1;
        hit_valid = 1'b1;
        hit_idx = m_mole;
        step();
        rst = 1'b0;
        m_mole = 4'd0;
        n_checks++;
        if ({mole_en, busy, game_over, hit_ok, miss} !== 5'b0 || {score, time_left, mole_idx} !== 19'd0) begin
            n_errors++;
            $display("[TB] FAIL midgame_reset: flags=%b score=%0d time=%0d idx=%0d expected 00000 0 0 0",
                     {mole_en, busy, game_over, hit_ok, miss}, score, time_left, mole_idx);
        end
        tick = 1'b1;
        step();
        n_checks++;
        if (busy !== 1'b0 || time_left !== 7'd0) begin
            n_errors++;
            $display("[TB] FAIL idle_after_reset: busy=%b time=%0d expected 0 0", busy, time_left);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_hit();
        test_miss();
        test_final_tick();
        test_reset_midgame();
        test_start();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
